phrase_sequencer: RTL and testbench

- Parametrised phoneme phrase player that replaces hard-wired phoneme test sequences.
- Holds a host-loadable phrase memory of phoneme codes and plays it on `start`. Each code goes to the downstream speech engine over the write/busy handshake.
- Supports variable phrase length, loop mode with an inter-phrase gap, abort, and a handshake timeout.
- Sits between the control/host logic and the speech engine (chatter) in the speech top level.

---
 rtl/phrase_sequencer.sv | 101 ++++++++++
 tb/tb_phrase_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/phrase_sequencer.sv
// phrase_sequencer: plays a host-loaded phrase of phoneme codes to the speech engine over write/busy handshake
module phrase_sequencer #(
  parameter int CODE_W      = 7,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int GAP_CYCLES  = 1024,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CODE_W-1:0] cfg_data,
  input  logic [ADDR_W:0]   phrase_len,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [CODE_W-1:0] code_out,
  output logic              code_write,
  input  logic              spk_busy,
  output logic              active,
  output logic              done,
  output logic [ADDR_W-1:0] cur_index
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, NEXT, GAP} state_t;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
  state_t state, state_n;
  logic [CODE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx, idx_n;
  logic [31:0] cnt, cnt_n;
  logic [ADDR_W:0] len;
  logic done_n;
  assign len = (phrase_len > MAX_LEN) ? MAX_LEN : phrase_len;
  always_ff @(posedge clk)
    if (cfg_we) mem[cfg_addr] <= cfg_data;
  // cnt is shared: ack timeout in WAIT_BUSY, gap length in GAP; cleared on entry to either
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 1;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!stop && start) begin
          if (len != '0) begin
            state_n = ISSUE;
            idx_n   = '0;
          end else done_n = 1'b1;
        end
      end
      ISSUE: begin
        state_n = WAIT_BUSY;
        cnt_n   = '0;
      end
      WAIT_BUSY: state_n = spk_busy ? WAIT_IDLE : (cnt >= ACK_TIMEOUT - 1) ? NEXT : WAIT_BUSY;
      WAIT_IDLE: state_n = spk_busy ? WAIT_IDLE : NEXT;
      NEXT: begin
        cnt_n = '0;
        if (stop) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (({1'b0, idx} + 1'b1) < len) begin
          idx_n   = idx + 1'b1;
          state_n = ISSUE;
        end else if (loop_en) begin
          idx_n   = '0;
          state_n = (GAP_CYCLES > 0) ? GAP : ISSUE;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        state_n = stop ? IDLE : (cnt >= GAP_CYCLES - 1) ? ISSUE : GAP;
        done_n  = stop;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      code_out   <= '0;
      code_write <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      cur_index  <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      code_write <= state == ISSUE;
      code_out   <= (state == ISSUE) ? mem[idx] : code_out;
      cur_index  <= (state == ISSUE) ? idx : cur_index;
      active     <= state_n != IDLE;
      done       <= done_n;
    end
endmodule

// File: tb/tb_phrase_sequencer.sv
// tb_phrase_sequencer: directed checks of phrase playback, looping, abort, timeout and reset
module tb_phrase_sequencer;
  logic clk = 0, rst_n = 1, cfg_we = 0, start = 0, stop = 0, loop_en = 0, spk_busy = 0;
  logic [3:0] cfg_addr = 0;
  logic [6:0] cfg_data = 0;
  logic [4:0] phrase_len = 0;
  logic [6:0] code_out;
  logic code_write, active, done;
  logic [3:0] cur_index;
  int checks = 0, errors = 0, cyc = 0, ndone = 0, bad_act = 0, bcnt = 0, n0 = 0;
  bit busy_on = 1, act_seen = 0;
  logic [6:0] wcode[$];
  int wcyc[$];
  logic [6:0] exp4 [4] = '{7'h1d, 7'h3b, 7'h21, 7'h35};

  phrase_sequencer #(.GAP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .phrase_len(phrase_len), .start(start), .stop(stop), .loop_en(loop_en),
    .code_out(code_out), .code_write(code_write), .spk_busy(spk_busy),
    .active(active), .done(done), .cur_index(cur_index)
  );

  always #5 clk = ~clk;

  // busy model: rises right after the write strobe is seen, held for 8 clocks
  always @(posedge clk) begin
    cyc++;
    #1;
    if (code_write && busy_on) bcnt = 8;
    spk_busy = bcnt > 0;
    if (bcnt > 0) bcnt--;
  end

  always @(negedge clk) begin
    if (code_write) begin
      wcode.push_back(code_out);
      wcyc.push_back(cyc);
    end
    if (done) begin
      ndone++;
      if (active) bad_act++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    int d0, i;
    d0 = ndone;
    i = 0;
    while (ndone == d0 && i < budget) begin
      tick();
      i++;
    end
    chk("done_seen", ndone != d0, 1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int i;
    i = 0;
    while (wcode.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk("writes_seen", wcode.size() >= n, 1);
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1;
    cfg_addr = a[3:0];
    cfg_data = d[6:0];
    tick();
    cfg_we = 0;
  endtask

  task automatic play();
    wcode.delete();
    wcyc.delete();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    #2;
    chk("rst_code_out", code_out, 0);
    chk("rst_code_write", code_write, 0);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_index", cur_index, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) wr(i, exp4[i]);
    for (int i = 4; i < 16; i++) wr(i, 'h40 + i);
    phrase_len = 4;
    // single pass, latency and spacing
    n0 = ndone;
    play();
    chk("lat_no_write_yet", code_write, 0);
    chk("active_in_issue", active, 1);
    tick();
    chk("lat_write", code_write, 1);
    chk("first_code", code_out, 7'h1d);
    chk("first_index", cur_index, 0);
    wait_done(200);
    repeat (5) tick();
    chk("pass_writes", wcode.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("pass_code%0d", i), wcode[i], exp4[i]);
    for (int i = 0; i < 3; i++) chk($sformatf("pass_gap%0d", i), wcyc[i+1] - wcyc[i], 11);
    chk("pass_done_once", ndone - n0, 1);
    chk("active_falls_with_done", bad_act, 0);
    chk("pass_active_end", active, 0);
    chk("pass_last_index", cur_index, 3);
    // loop with gap, abort during second pass at index 1
    loop_en = 1;
    n0 = ndone;
    play();
    wait_writes(6, 300);
    stop = 1;
    chk("loop_no_done", ndone - n0, 0);
    wait_done(100);
    stop = 0;
    loop_en = 0;
    repeat (5) tick();
    chk("loop_writes", wcode.size(), 6);
    chk("loop_code3", wcode[3], 7'h35);
    chk("loop_code4", wcode[4], 7'h1d);
    chk("loop_code5", wcode[5], 7'h3b);
    chk("loop_gap_spacing", wcyc[4] - wcyc[3], 15);
    chk("loop_inner_spacing", wcyc[5] - wcyc[4], 11);
    chk("abort_done_once", ndone - n0, 1);
    chk("abort_index", cur_index, 1);
    // zero length
    phrase_len = 0;
    n0 = ndone;
    act_seen = 0;
    play();
    repeat (4) begin
      if (active) act_seen = 1;
      tick();
    end
    chk("len0_active", act_seen, 0);
    chk("len0_writes", wcode.size(), 0);
    chk("len0_done", ndone - n0, 1);
    // length clamped to depth
    phrase_len = 20;
    n0 = ndone;
    play();
    wait_done(400);
    repeat (3) tick();
    chk("clamp_writes", wcode.size(), 16);
    chk("clamp_code4", wcode[4], 7'h44);
    chk("clamp_code15", wcode[15], 7'h4f);
    chk("clamp_index", cur_index, 15);
    chk("clamp_done", ndone - n0, 1);
    // busy never rises: ack timeout
    busy_on = 0;
    phrase_len = 4;
    n0 = ndone;
    play();
    wait_done(300);
    repeat (3) tick();
    chk("tmo_writes", wcode.size(), 4);
    chk("tmo_code3", wcode[3], 7'h35);
    chk("tmo_spacing", wcyc[1] - wcyc[0], 17);
    chk("tmo_done", ndone - n0, 1);
    busy_on = 1;
    // async reset in the middle of a handshake
    play();
    wait_writes(1, 20);
    tick();
    chk("pre_rst_code", code_out, 7'h1d);
    #2 rst_n = 0;
    #1;
    chk("async_rst_code", code_out, 0);
    chk("async_rst_active", active, 0);
    repeat (12) tick();
    rst_n = 1;
    tick();
    chk("post_rst_active", active, 0);
    play();
    wait_done(200);
    chk("replay_writes", wcode.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("replay_code%0d", i), wcode[i], exp4[i]);
    // live memory update and start held high
    wcode.delete();
    wcyc.delete();
    start = 1;
    tick();
    wait_writes(2, 50);
    wr(3, 'h02);
    wait_writes(4, 100);
    start = 0;
    wait_done(100);
    repeat (5) tick();
    chk("live_writes", wcode.size(), 4);
    chk("live_code2", wcode[2], 7'h21);
    chk("live_code3", wcode[3], 7'h02);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
